// File: rtl/negate_pkg.sv
// Shared definitions for the negate_pipe datapath: mode encoding, internal
// arithmetic width and the signed output range used for overflow/saturation.
package negate_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_NABS = 2'b11
    } mode_e;

    // Two guard bits keep -x and |x| exact for every representable input.
    function automatic int calc_w(input int bw_in, input int bw_out);
        return ((bw_in > bw_out) ? bw_in : bw_out) + 2;
    endfunction

    function automatic longint sat_max(input int bw_out);
        return (longint'(1) << (bw_out - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int bw_out);
        return -(longint'(1) << (bw_out - 1));
    endfunction

endpackage

// File: rtl/negate_lane.sv
// One channel of sign manipulation: extend, apply mode, flag values that do
// not fit the signed output range, then wrap or clip to the output width.
module negate_lane
    import negate_pkg::*;
#(
    parameter int BW_IN     = 8,
    parameter int BW_OUT    = 8,
    parameter int IN_SIGNED = 1,
    parameter int SATURATE  = 0
) (
    input  logic [BW_IN-1:0]  x,
    input  logic [1:0]        mode,
    output logic [BW_OUT-1:0] y,
    output logic              ovf
);

    localparam int W = calc_w(BW_IN, BW_OUT);
    localparam logic signed [W-1:0] MAX_W = W'(sat_max(BW_OUT));
    localparam logic signed [W-1:0] MIN_W = W'(sat_min(BW_OUT));

    logic                ext_bit;
    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] x_neg;
    logic signed [W-1:0] result;

    assign ext_bit = (IN_SIGNED != 0) ? x[BW_IN-1] : 1'b0;
    assign x_ext   = {{(W - BW_IN){ext_bit}}, x};
    assign x_neg   = -x_ext;

    always_comb begin
        result = x_ext;
        case (mode_e'(mode))
            MODE_PASS: result = x_ext;
            MODE_NEG:  result = x_neg;
            MODE_ABS:  result = x_ext[W-1] ? x_neg : x_ext;
            MODE_NABS: result = x_ext[W-1] ? x_ext : x_neg;
            default:   result = x_ext;
        endcase
    end

    assign ovf = (result > MAX_W) || (result < MIN_W);

    // Wrapping keeps the low bits, matching the legacy negate block bit for bit.
    always_comb begin
        y = result[BW_OUT-1:0];
        if ((SATURATE != 0) && ovf) begin
            y = result[W-1] ? MIN_W[BW_OUT-1:0] : MAX_W[BW_OUT-1:0];
        end
    end

endmodule

// File: rtl/negate_pipe.sv
// Multi-channel sign-manipulation unit: combinational lanes feed a chain of
// bubble-collapsing valid/ready register stages with sticky overflow status.
module negate_pipe
    import negate_pkg::*;
#(
    parameter int CH        = 4,
    parameter int BW_IN     = 8,
    parameter int BW_OUT    = 8,
    parameter int IN_SIGNED = 1,
    parameter int SATURATE  = 0,
    parameter int STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*BW_IN-1:0]  in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*BW_OUT-1:0] out_data,
    output logic [CH-1:0]        out_ovf,
    output logic [CH-1:0]        ovf_sticky,
    input  logic                 clr_ovf
);

    logic [CH*BW_OUT-1:0] lane_data;
    logic [CH-1:0]        lane_ovf;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        negate_lane #(
            .BW_IN    (BW_IN),
            .BW_OUT   (BW_OUT),
            .IN_SIGNED(IN_SIGNED),
            .SATURATE (SATURATE)
        ) u_lane (
            .x   (in_data[k*BW_IN +: BW_IN]),
            .mode(in_mode),
            .y   (lane_data[k*BW_OUT +: BW_OUT]),
            .ovf (lane_ovf[k])
        );
    end

    logic [STAGES-1:0]    stg_valid;
    logic [STAGES-1:0]    stg_ready;
    logic [CH*BW_OUT-1:0] stg_data [STAGES];
    logic [CH-1:0]        stg_ovf  [STAGES];

    // A stage can load unless it and every stage after it are full and the
    // sink is stalled; written flat so the ready chain has no self-loop.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic                 up_valid;
        logic [CH*BW_OUT-1:0] up_data;
        logic [CH-1:0]        up_ovf;
        logic                 valid_q;
        logic [CH*BW_OUT-1:0] data_q;
        logic [CH-1:0]        ovf_q;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = lane_data;
            assign up_ovf   = lane_ovf;
        end else begin : g_body
            assign up_valid = stg_valid[i-1];
            assign up_data  = stg_data[i-1];
            assign up_ovf   = stg_ovf[i-1];
        end

        assign stg_ready[i] = out_ready | ~(&stg_valid[STAGES-1:i]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                ovf_q   <= '0;
            end else if (stg_ready[i]) begin
                valid_q <= up_valid;
                if (up_valid) begin
                    data_q <= up_data;
                    ovf_q  <= up_ovf;
                end
            end
        end

        assign stg_valid[i] = valid_q;
        assign stg_data[i]  = data_q;
        assign stg_ovf[i]   = ovf_q;
    end

    assign in_ready  = stg_ready[0];
    assign out_valid = stg_valid[STAGES-1];
    assign out_data  = stg_data[STAGES-1];
    assign out_ovf   = stg_ovf[STAGES-1];

    // A clear and a new overflow in the same cycle leave the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= '0;
        end else begin
            ovf_sticky <= (clr_ovf ? '0 : ovf_sticky)
                        | ((out_valid && out_ready) ? out_ovf : '0);
        end
    end

endmodule

// File: tb/tb_negate_pipe.sv
// Bench for negate_pipe: three parameterisations share one handshake stream and
// are checked against an integer reference model plus directed corner cases.
module tb_negate_pipe;

    localparam int STAGES = 2;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  ovf;
        int          acc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [15:0] in_data_c;
    logic [1:0]  in_mode;
    logic        out_ready;
    logic        clr_ovf;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [31:0] out_data_a, out_data_b, out_data_c;
    logic [3:0]  out_ovf_a, out_ovf_b, out_ovf_c;
    logic [3:0]  sticky_a, sticky_b, sticky_c;

    int check_count = 0;
    int fail_count  = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        in_data_c = '0;
        for (int k = 0; k < 4; k++) in_data_c[k*4 +: 4] = in_data[k*8 +: 4];
    end

    negate_pipe #(.CH(4), .BW_IN(8), .BW_OUT(8), .IN_SIGNED(1), .SATURATE(0), .STAGES(STAGES)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ovf(out_ovf_a), .ovf_sticky(sticky_a), .clr_ovf(clr_ovf));

    negate_pipe #(.CH(4), .BW_IN(8), .BW_OUT(8), .IN_SIGNED(1), .SATURATE(1), .STAGES(STAGES)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ovf(out_ovf_b), .ovf_sticky(sticky_b), .clr_ovf(clr_ovf));

    negate_pipe #(.CH(4), .BW_IN(4), .BW_OUT(8), .IN_SIGNED(0), .SATURATE(0), .STAGES(STAGES)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data_c), .in_mode(in_mode), .out_valid(out_valid_c), .out_ready(out_ready),
        .out_data(out_data_c), .out_ovf(out_ovf_c), .ovf_sticky(sticky_c), .clr_ovf(clr_ovf));

    logic        i_ready [3];
    logic        o_valid [3];
    logic [31:0] o_data  [3];
    logic [3:0]  o_ovf   [3];
    logic [3:0]  o_stick [3];

    assign i_ready[0] = in_ready_a;  assign i_ready[1] = in_ready_b;  assign i_ready[2] = in_ready_c;
    assign o_valid[0] = out_valid_a; assign o_valid[1] = out_valid_b; assign o_valid[2] = out_valid_c;
    assign o_data[0]  = out_data_a;  assign o_data[1]  = out_data_b;  assign o_data[2]  = out_data_c;
    assign o_ovf[0]   = out_ovf_a;   assign o_ovf[1]   = out_ovf_b;   assign o_ovf[2]   = out_ovf_c;
    assign o_stick[0] = sticky_a;    assign o_stick[1] = sticky_b;    assign o_stick[2] = sticky_c;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Index 0: signed wrap, 1: signed saturate, 2: unsigned 4-bit input.
    function automatic beat_t ref_beat(input int dut_idx, input logic [31:0] d, input logic [1:0] m);
        beat_t b;
        b.data = '0;
        b.ovf  = '0;
        b.acc  = 0;
        for (int k = 0; k < 4; k++) begin
            int x;
            int r;
            logic [7:0] byte_val;
            byte_val = d[k*8 +: 8];
            if (dut_idx == 2) x = int'(byte_val[3:0]);
            else              x = int'($signed(byte_val));
            case (m)
                2'd0:    r = x;
                2'd1:    r = -x;
                2'd2:    r = (x < 0) ? -x : x;
                default: r = (x < 0) ? x : -x;
            endcase
            b.ovf[k] = (r > 127) || (r < -128);
            if (dut_idx == 1 && b.ovf[k]) r = (r > 127) ? 127 : -128;
            b.data[k*8 +: 8] = r[7:0];
        end
        return b;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_mon
        beat_t       q[$];
        int          pending    = 0;
        int          last_stall = -1;
        logic [3:0]  sticky_m   = '0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data  = '0;
        logic [3:0]  prev_ovf   = '0;

        always @(negedge clk) begin : mon_body
            beat_t      b;
            logic [3:0] hs_ovf;
            hs_ovf = '0;
            if (!rst_n) begin
                q.delete();
                sticky_m   = '0;
                prev_stall = 1'b0;
                last_stall = -1;
            end else begin
                checkOutput($sformatf("in_ready[%0d]", i), i_ready[i], (q.size() < STAGES) || out_ready);
                checkOutput($sformatf("ovf_sticky[%0d]", i), o_stick[i], sticky_m);
                if (prev_stall) begin
                    checkOutput($sformatf("stall_valid[%0d]", i), o_valid[i], 1);
                    checkOutput($sformatf("stall_data[%0d]", i), o_data[i], prev_data);
                    checkOutput($sformatf("stall_ovf[%0d]", i), o_ovf[i], prev_ovf);
                end
                if (o_valid[i] && q.size() == 0) begin
                    checkOutput($sformatf("stale_beat[%0d]", i), o_valid[i], 0);
                end else if (o_valid[i] && out_ready) begin
                    b = q.pop_front();
                    hs_ovf = b.ovf;
                    checkOutput($sformatf("out_data[%0d]", i), o_data[i], b.data);
                    checkOutput($sformatf("out_ovf[%0d]", i), o_ovf[i], b.ovf);
                    if (last_stall < b.acc)
                        checkOutput($sformatf("latency[%0d]", i), cyc - b.acc, STAGES);
                end
                if (!out_ready) last_stall = cyc;
                sticky_m = (clr_ovf ? 4'b0 : sticky_m) | hs_ovf;
                if (in_valid && i_ready[i]) begin
                    b = ref_beat(i, in_data, in_mode);
                    b.acc = cyc;
                    q.push_back(b);
                end
                prev_stall = o_valid[i] && !out_ready;
                prev_data  = o_data[i];
                prev_ovf   = o_ovf[i];
            end
            pending = q.size();
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        @(negedge clk);
        while (!in_ready_a && n < 50) begin
            n++;
            @(negedge clk);
        end
        checkOutput("send_accept", in_ready_a, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        int n;
        n   = 0;
        lat = 1;
        @(negedge clk);
        while (!out_valid_a && n < 20) begin
            lat++;
            n++;
            @(negedge clk);
        end
        checkOutput("wait_valid", out_valid_a, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lat;
        logic [7:0] got[$];
        logic       min_ready;
        logic [31:0] rnd;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'd0;
        out_ready = 1'b1; clr_ovf = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid_a, 0);
        checkOutput("rst_out_data", out_data_a, 0);
        checkOutput("rst_sticky", sticky_a, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("rst_in_ready", in_ready_a, 1);

        // Mixed-sign negate, including the most-negative and most-positive codes.
        applyStimulus(32'h7F80FE05, 2'd1);
        waitValid(lat);
        checkOutput("neg_latency", lat, STAGES);
        checkOutput("neg_data_wrap", out_data_a, 32'h818002FB);
        checkOutput("neg_ovf_wrap", out_ovf_a, 4'b0100);
        checkOutput("neg_data_sat", out_data_b, 32'h817F02FB);
        checkOutput("neg_ovf_sat", out_ovf_b, 4'b0100);
        checkOutput("neg_data_uns", out_data_c, 32'hF100F2FB);
        checkOutput("neg_ovf_uns", out_ovf_c, 4'b0000);
        @(posedge clk); #1;
        checkOutput("sticky_set_a", sticky_a, 4'b0100);
        checkOutput("sticky_set_c", sticky_c, 4'b0000);

        applyStimulus(32'h00000080, 2'd2);
        waitValid(lat);
        checkOutput("abs80_wrap", out_data_a, 32'h00000080);
        checkOutput("abs80_ovf", out_ovf_a, 4'b0001);
        checkOutput("abs80_sat", out_data_b, 32'h0000007F);
        @(posedge clk); #1;

        applyStimulus(32'h0000000F, 2'd0);
        waitValid(lat);
        checkOutput("pass_uns", out_data_c, 32'h0000000F);
        checkOutput("pass_wrap", out_data_a, 32'h0000000F);
        @(posedge clk); #1;

        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        checkOutput("sticky_clr", sticky_a, 4'b0000);

        out_ready = 1'b0;
        applyStimulus(32'h00000080, 2'd1);
        waitValid(lat);
        out_ready = 1'b1;
        clr_ovf   = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        checkOutput("sticky_set_wins_a", sticky_a, 4'b0001);
        checkOutput("sticky_set_wins_b", sticky_b, 4'b0001);

        // Six-beat stream with a four-cycle sink stall.
        min_ready = 1'b1;
        fork
            for (int v = 1; v <= 6; v++) applyStimulus({4{8'(v)}}, 2'd0);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (!in_ready_a) min_ready = 1'b0;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
            repeat (30) begin
                @(negedge clk);
                if (out_valid_a && out_ready) got.push_back(out_data_a[7:0]);
            end
        join
        checkOutput("bp_in_ready_drop", min_ready, 0);
        checkOutput("bp_count", got.size(), 6);
        for (int j = 0; j < got.size() && j < 6; j++) checkOutput("bp_order", got[j], j + 1);
        @(posedge clk); #1;

        out_ready = 1'b0;
        applyStimulus(32'h01010101, 2'd0);
        applyStimulus(32'h02020202, 2'd0);
        checkOutput("midrst_pre_valid", out_valid_a, 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", out_valid_a, 0);
        checkOutput("midrst_data", out_data_a, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("midrst_no_stale", out_valid_a, 0);
        end
        @(posedge clk); #1;
        applyStimulus(32'h05050505, 2'd1);
        waitValid(lat);
        checkOutput("midrst_latency", lat, STAGES);
        checkOutput("midrst_data_new", out_data_a, 32'hFBFBFBFB);
        @(posedge clk); #1;

        // Random traffic with corner codes mixed in; the monitors do the checking.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                rnd = $urandom;
                case ($urandom_range(0, 5))
                    0:       in_data[k*8 +: 8] = 8'h80;
                    1:       in_data[k*8 +: 8] = 8'h7F;
                    2:       in_data[k*8 +: 8] = 8'hFF;
                    default: in_data[k*8 +: 8] = rnd[7:0];
                endcase
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("drain_a", g_mon[0].pending, 0);
        checkOutput("drain_b", g_mon[1].pending, 0);
        checkOutput("drain_c", g_mon[2].pending, 0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/negate_pipe.md
Name: negate_pipe

Overview:
Multi-channel, pipelined sign-manipulation unit for the generated dense-layer datapath. Per beat it applies one of four modes to every channel: pass, negate, abs or negative-abs. Width extension follows the existing negate rules; optional saturation and per-channel overflow status are added. A valid/ready handshake with bubble-collapsing pipeline stages lets it sit between accumulator outputs and the activation or quantiser stages under backpressure.

Parameters:
CH, 4, number of parallel channels packed in one beat
BW_IN, 8, bits per input channel
BW_OUT, 8, bits per output channel (two's complement result)
IN_SIGNED, 1, 1 = inputs are two's complement; 0 = inputs are unsigned
SATURATE, 0, 1 = clip to the BW_OUT signed range; 0 = keep the BW_OUT LSBs (wrap)
STAGES, 2, number of register stages (1..4); equals latency in cycles

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  CH*BW_IN  channel k at bits [k*BW_IN +: BW_IN]
in_mode  in  2  00 pass, 01 negate, 10 abs, 11 neg-abs; applies to all channels of the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  CH*BW_OUT  channel k at bits [k*BW_OUT +: BW_OUT]
out_ovf  out  CH  per-channel overflow for the current output beat
ovf_sticky  out  CH  sticky OR of out_ovf over accepted output beats
clr_ovf  in  1  single-cycle pulse; clears ovf_sticky

Behaviour:
- Reset: all stage valids, out_valid, out_data, out_ovf and ovf_sticky go to 0 immediately and asynchronously. Beats in flight are discarded, not flushed. in_ready is 1 after reset deasserts.
- Arithmetic (stage 0): extend each channel to W = max(BW_IN, BW_OUT) + 2 bits, sign-extended if IN_SIGNED else zero-extended.
- Mode results: pass gives x; negate gives -x; abs gives (x<0 ? -x : x); neg-abs gives (x<0 ? x : -x). Computed exactly in W bits.
- Representability: ovf[k] = result outside [-2^(BW_OUT-1), 2^(BW_OUT-1)-1].
- Clipping: if SATURATE, clip to that range; else take result[BW_OUT-1:0], which is bit-identical to the existing negate block for mode 01.
- Overflow example: unsigned x >= 2^(BW_OUT-1) in pass mode flags ovf.
- Pipeline: stage i register loads when ready_i = ~valid_i | ready_(i+1), with ready_STAGES = out_ready. in_ready = ready_0, combinational. out_* are driven directly from the last stage.
- Bubble collapsing: an empty stage accepts even while downstream is stalled.
- Latency: STAGES cycles from input handshake to out_valid when out_ready is held high. Throughput is 1 beat/cycle. Beat order is preserved; no beat is dropped or duplicated.
- Data stability: out_data and out_ovf hold while out_valid & ~out_ready.
- Sticky status: ovf_sticky[k] is set on an output handshake with out_ovf[k]. clr_ovf clears it. If clr and set occur in the same cycle, set wins (the bit reads 1 next cycle).
- Arithmetic work is confined to stage 0; later stages only register. STAGES>1 exists for timing/retiming only.

Decomposition:
- Package negate_pkg: mode encoding constants (MODE_PASS/NEG/ABS/NABS), function for internal width W, saturation bounds functions.
- One sub-module: negate_lane, combinational, one channel: extend, mode select, ovf, clip. Instantiate CH lanes in a generate loop.
- The handshake pipeline lives in the top level.

Test Plan:
- Negate, CH=2, signed 8/8, STAGES=2: in_data {8'h05, 8'hFE}, mode 01 -> out {8'hFB, 8'h02} exactly 2 cycles after accept; ovf=0.
- Most-negative input: mode 01 on 8'h80. SATURATE=0 -> 8'h80 with ovf=1. SATURATE=1 -> 8'h7F with ovf=1. Mode 10 on 8'h80 gives the same results.
- Unsigned extension, IN_SIGNED=0, BW_IN=4, BW_OUT=8: 4'hF mode 01 -> 8'hF1 with ovf=0. Mode 00 -> 8'h0F.
- Backpressure: stream 6 beats (values 1..6), out_ready low for cycles 3-6. in_ready drops after the stages fill. Outputs are 1..6 in order, no loss, and out_data is stable while stalled.
- Sticky status: overflow beat accepted -> ovf_sticky=1. Pulse clr_ovf alone -> 0. clr_ovf in the same cycle as a new overflow handshake -> remains 1.
- Reset mid-stream: assert rst_n low with 2 beats in flight. out_valid falls immediately and no stale beat appears after release. The first new beat emerges STAGES cycles after accept.
